// File: rtl/cpuy_sequencer_if.sv
// cpuy_sequencer_if: program-ROM fetch bus between the cpuy sequencer and its ROM.
//   rom_rd   - read request, held high until acknowledged
//   rom_addr - byte address (the sequencer's PC)
//   rom_data - read data, valid in the cycle rom_ack is high
//   rom_ack  - data valid / request accepted
// master modport: sequencer side; slave modport: ROM side.
interface cpuy_sequencer_if #(
    parameter int unsigned PC_W = 8
);
    logic            rom_rd;
    logic [PC_W-1:0] rom_addr;
    logic [7:0]      rom_data;
    logic            rom_ack;

    modport master (output rom_rd, rom_addr, input  rom_data, rom_ack);
    modport slave  (input  rom_rd, rom_addr, output rom_data, rom_ack);
endinterface

// File: rtl/cpuy_sequencer.sv
// cpuy_sequencer: fetch/execute controller for the cpuy core.
// Fetches opcode and W operand from program ROM, hands them to the clocked
// ucode decoder, then steps the datapath through EXEC, optional high-byte
// writeback and optional stack phase. Owns PC, SP, halt and fault state.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   halt_req             - stop at the next instruction boundary
//   rom                  - ROM fetch bus (master modport)
//   opcode, w            - latched instruction bytes to the decoder
//   jump_*, stack_*,
//   alu_multibyte_result - registered decoder outputs
//   exec_en, wb_hi_en,
//   stack_push, stack_pop- one-cycle datapath strobes
//   sp, state            - stack pointer and debug FSM state
//   halted, fault        - HALT indication, sticky stack fault
module cpuy_sequencer #(
    parameter int unsigned     PC_W     = 8,
    parameter int unsigned     SP_W     = 3,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                halt_req,
    cpuy_sequencer_if.master    rom,
    output logic [7:0]          opcode,
    output logic [7:0]          w,
    input  logic                jump_operation,
    input  logic                jump_condition,
    input  logic                stack_operation,
    input  logic                stack_direction,
    input  logic                alu_multibyte_result,
    output logic                exec_en,
    output logic                wb_hi_en,
    output logic                stack_push,
    output logic                stack_pop,
    output logic [SP_W-1:0]     sp,
    output logic [3:0]          state,
    output logic                halted,
    output logic                fault
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH_OP = 4'd1,
        FETCH_W  = 4'd2,
        DECODE   = 4'd3,
        EXEC     = 4'd4,
        WB_HI    = 4'd5,
        STACK    = 4'd6,
        HALT     = 4'd7,
        FAULT    = 4'd8
    } state_t;

    state_t          st;
    state_t          bnd_state;
    logic [PC_W-1:0] pc;
    logic            rd_q;
    logic            sp_full;
    logic            sp_empty;
    logic            push_ok;
    logic            pop_ok;

    assign rom.rom_rd   = rd_q;
    assign rom.rom_addr = pc;
    assign state        = st;

    always_comb begin
        sp_full   = (sp == '1);
        sp_empty  = (sp == '0);
        push_ok   = stack_direction && !sp_full;
        pop_ok    = !stack_direction && !sp_empty;
        bnd_state = halt_req ? HALT : FETCH_OP;
    end

    // Every output is a register loaded on the transition into the state it
    // belongs to, so strobes line up exactly with their state and nothing
    // combinational reaches them from rom_ack. The stack strobe is decided on
    // entry to STACK from the SP value that STACK itself will test.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= IDLE;
            pc         <= RESET_PC;
            sp         <= '0;
            opcode     <= '0;
            w          <= '0;
            rd_q       <= 1'b0;
            exec_en    <= 1'b0;
            wb_hi_en   <= 1'b0;
            stack_push <= 1'b0;
            stack_pop  <= 1'b0;
            halted     <= 1'b0;
            fault      <= 1'b0;
        end else begin
            exec_en    <= 1'b0;
            wb_hi_en   <= 1'b0;
            stack_push <= 1'b0;
            stack_pop  <= 1'b0;
            case (st)
                IDLE: begin
                    st     <= bnd_state;
                    halted <= halt_req;
                    rd_q   <= !halt_req;
                end
                FETCH_OP: begin
                    if (rom.rom_ack) begin
                        opcode <= rom.rom_data;
                        pc     <= pc + PC_W'(1);
                        st     <= FETCH_W;
                    end
                end
                FETCH_W: begin
                    if (rom.rom_ack) begin
                        w    <= rom.rom_data;
                        pc   <= pc + PC_W'(1);
                        rd_q <= 1'b0;
                        st   <= DECODE;
                    end
                end
                DECODE: begin
                    st      <= EXEC;
                    exec_en <= 1'b1;
                end
                EXEC: begin
                    if (jump_operation && jump_condition) begin
                        pc <= PC_W'(w);
                    end
                    if (alu_multibyte_result) begin
                        st       <= WB_HI;
                        wb_hi_en <= 1'b1;
                    end else if (stack_operation) begin
                        st         <= STACK;
                        stack_push <= push_ok;
                        stack_pop  <= pop_ok;
                    end else begin
                        st     <= bnd_state;
                        halted <= halt_req;
                        rd_q   <= !halt_req;
                    end
                end
                WB_HI: begin
                    if (stack_operation) begin
                        st         <= STACK;
                        stack_push <= push_ok;
                        stack_pop  <= pop_ok;
                    end else begin
                        st     <= bnd_state;
                        halted <= halt_req;
                        rd_q   <= !halt_req;
                    end
                end
                STACK: begin
                    if (stack_direction ? sp_full : sp_empty) begin
                        fault <= 1'b1;
                        st    <= FAULT;
                    end else begin
                        sp     <= stack_direction ? sp + SP_W'(1) : sp - SP_W'(1);
                        st     <= bnd_state;
                        halted <= halt_req;
                        rd_q   <= !halt_req;
                    end
                end
                HALT: begin
                    if (!halt_req) begin
                        st     <= FETCH_OP;
                        halted <= 1'b0;
                        rd_q   <= 1'b1;
                    end
                end
                FAULT: begin
                    st <= FAULT;
                end
                default: begin
                    st <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpuy_sequencer.sv
// tb_cpuy_sequencer: scoreboard bench for cpuy_sequencer. An instruction-level
// reference model turns ROM contents into the expected event stream (fetch
// addresses, strobes with their operands, fault); a negedge monitor pops and
// compares as the DUT produces events. Directed timelines add cycle checks.
module tb_cpuy_sequencer;
    localparam int unsigned PC_W = 8;
    localparam int unsigned SP_W = 3;

    localparam logic [2:0] K_FETCH = 3'd0;
    localparam logic [2:0] K_EXEC  = 3'd1;
    localparam logic [2:0] K_WB    = 3'd2;
    localparam logic [2:0] K_PUSH  = 3'd3;
    localparam logic [2:0] K_POP   = 3'd4;
    localparam logic [2:0] K_FAULT = 3'd5;

    typedef struct packed {
        logic [2:0]  kind;
        logic [15:0] val;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic halt_req = 1'b0;
    always #5 clk = ~clk;

    cpuy_sequencer_if #(.PC_W(PC_W)) rom ();

    logic [7:0]      opcode, w;
    logic            jop, jcond, sop, sdir, mb;
    logic            exec_en, wb_hi_en, stack_push, stack_pop;
    logic [SP_W-1:0] sp;
    logic [3:0]      state;
    logic            halted, fault;

    cpuy_sequencer #(.PC_W(PC_W), .SP_W(SP_W), .RESET_PC('0)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .halt_req             (halt_req),
        .rom                  (rom.master),
        .opcode               (opcode),
        .w                    (w),
        .jump_operation       (jop),
        .jump_condition       (jcond),
        .stack_operation      (sop),
        .stack_direction      (sdir),
        .alu_multibyte_result (mb),
        .exec_en              (exec_en),
        .wb_hi_en             (wb_hi_en),
        .stack_push           (stack_push),
        .stack_pop            (stack_pop),
        .sp                   (sp),
        .state                (state),
        .halted               (halted),
        .fault                (fault)
    );

    // Clocked ucode decoder stand-in: opcode bit 7 jump, 6 condition,
    // 5 stack op, 4 push(1)/pop(0), 3 multibyte result.
    always_ff @(posedge clk) {jop, jcond, sop, sdir, mb} <= opcode[7:3];

    int   n_checks = 0;
    int   n_pass   = 0;
    ev_t  exp_q[$];
    logic [7:0] rom_mem [256];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic ev_t mk(input logic [2:0] kind, input logic [15:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        return e;
    endfunction

    // ---------------- monitor ----------------
    logic fault_seen = 1'b0;

    task automatic observe(input logic [2:0] kind, input logic [15:0] val);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_event: got kind %0d val %h, expected no event", kind, val);
        end else begin
            e = exp_q.pop_front();
            check("event", {kind, val}, {e.kind, e.val});
        end
    endtask

    always @(negedge clk) begin
        int ns;
        if (!rst_n) begin
            fault_seen = 1'b0;
        end else begin
            ns = int'(exec_en) + int'(wb_hi_en) + int'(stack_push) + int'(stack_pop);
            if (rom.rom_rd && rom.rom_ack) observe(K_FETCH, {8'h00, rom.rom_addr});
            if (exec_en)    observe(K_EXEC, {opcode, w});
            if (wb_hi_en)   observe(K_WB, 16'h0000);
            if (stack_push) observe(K_PUSH, {13'b0, sp});
            if (stack_pop)  observe(K_POP, {13'b0, sp});
            if (ns != 0) check("strobe_onehot", 64'(ns), 64'd1);
            if (fault && !fault_seen) begin
                fault_seen = 1'b1;
                observe(K_FAULT, 16'h0000);
            end
            if (fault_seen)
                check("quiet_after_fault", {rom.rom_rd, exec_en, wb_hi_en, stack_push, stack_pop}, 64'd0);
        end
    end

    // ---------------- ROM responder ----------------
    int ack_budget = 0;
    int wait_mode  = 0;   // >=0 fixed waits, -1 random 0..3, -2 opcode 0 / operand 3
    int fetch_idx  = 0;
    int waits_left = -1;

    initial begin
        rom.rom_ack  = 1'b0;
        rom.rom_data = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            rom.rom_ack = 1'b0;
            if (!rst_n) begin
                waits_left = -1;
                fetch_idx  = 0;
            end else if (rom.rom_rd && ack_budget > 0) begin
                if (waits_left < 0) begin
                    if (wait_mode == -1)      waits_left = int'($urandom_range(0, 3));
                    else if (wait_mode == -2) waits_left = fetch_idx[0] ? 3 : 0;
                    else                      waits_left = wait_mode;
                end
                if (waits_left == 0) begin
                    rom.rom_ack  = 1'b1;
                    rom.rom_data = rom_mem[rom.rom_addr];
                    ack_budget--;
                    fetch_idx++;
                    waits_left = -1;
                end else begin
                    waits_left--;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]      exp_pc;
    logic [SP_W-1:0] exp_sp;
    bit              exp_fault;

    task automatic model(input int n, output int nfetch, output logic [7:0] pc_end,
                         output logic [SP_W-1:0] sp_end, output bit faulted);
        int pc = 0;
        int spm = 0;
        logic [7:0] op, wv;
        nfetch  = 0;
        faulted = 0;
        for (int i = 0; i < n && !faulted; i++) begin
            op = rom_mem[pc];
            exp_q.push_back(mk(K_FETCH, 16'(pc)));
            pc = (pc + 1) % 256;
            wv = rom_mem[pc];
            exp_q.push_back(mk(K_FETCH, 16'(pc)));
            pc = (pc + 1) % 256;
            nfetch += 2;
            exp_q.push_back(mk(K_EXEC, {op, wv}));
            if (op[7] && op[6]) pc = int'(wv);
            if (op[3]) exp_q.push_back(mk(K_WB, 16'h0000));
            if (op[5]) begin
                if (op[4]) begin
                    if (spm == (1 << SP_W) - 1) begin
                        exp_q.push_back(mk(K_FAULT, 16'h0000));
                        faulted = 1;
                    end else begin
                        exp_q.push_back(mk(K_PUSH, 16'(spm)));
                        spm++;
                    end
                end else begin
                    if (spm == 0) begin
                        exp_q.push_back(mk(K_FAULT, 16'h0000));
                        faulted = 1;
                    end else begin
                        exp_q.push_back(mk(K_POP, 16'(spm)));
                        spm--;
                    end
                end
            end
        end
        pc_end = 8'(pc);
        sp_end = SP_W'(spm);
    endtask

    // ---------------- phase helpers ----------------
    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, {rom.rom_rd, exec_en, wb_hi_en, stack_push, stack_pop,
                               halted, fault, state, sp}, 64'd0);
        check({tag, "_data"}, {rom.rom_addr, opcode, w}, 64'd0);
    endtask

    task automatic start_phase(input int n, input int wmode);
        int nf;
        rst_n      = 1'b0;
        halt_req   = 1'b0;
        ack_budget = 0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_state");
        model(n, nf, exp_pc, exp_sp, exp_fault);
        wait_mode  = wmode;
        ack_budget = nf;
        rst_n      = 1'b1;
    endtask

    task automatic finish_phase(input string tag);
        int c = 0;
        while (exp_q.size() > 0 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        if (exp_fault)
            check({tag, "_fault_end"}, {state, fault, rom.rom_rd, sp}, {4'd8, 1'b1, 1'b0, exp_sp});
        else
            check({tag, "_next_fetch"}, {rom.rom_rd, rom.rom_addr, sp}, {1'b1, exp_pc, exp_sp});
    endtask

    logic       tl_rd   [16];
    logic [7:0] tl_addr [16];
    logic [7:0] tl_w    [16];
    logic [3:0] tl_strb [16];

    task automatic capture(input int n);
        int c = 0;
        @(negedge clk);
        while (!rom.rom_rd && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("first_fetch_seen", rom.rom_rd, 1);
        for (int i = 0; i < n; i++) begin
            tl_rd[i]   = rom.rom_rd;
            tl_addr[i] = rom.rom_addr;
            tl_w[i]    = w;
            tl_strb[i] = {exec_en, wb_hi_en, stack_push, stack_pop};
            if (i < n - 1) @(negedge clk);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom_mem[i] = 8'h00;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c;
        clear_rom();

        // plain instruction timeline
        rom_mem[0] = 8'h10; rom_mem[1] = 8'h55;
        start_phase(1, 0);
        capture(6);
        check("plain_c1_addr", {tl_rd[0], tl_addr[0]}, {1'b1, 8'h00});
        check("plain_c2_addr", {tl_rd[1], tl_addr[1]}, {1'b1, 8'h01});
        check("plain_c3_quiet", tl_strb[2], 4'b0000);
        check("plain_c4_exec", tl_strb[3], 4'b1000);
        check("plain_c5_fetch", {tl_rd[4], tl_addr[4]}, {1'b1, 8'h02});
        finish_phase("plain");

        // jump taken / not taken
        rom_mem[0] = 8'hC0; rom_mem[1] = 8'h80;
        start_phase(1, 0);
        finish_phase("jump_taken");
        rom_mem[0] = 8'h80;
        start_phase(1, 0);
        finish_phase("jump_not_taken");

        // operand fetch delayed by three wait cycles
        rom_mem[0] = 8'h10; rom_mem[1] = 8'h55;
        start_phase(1, -2);
        capture(8);
        for (int i = 1; i <= 4; i++)
            check("wait_rd_addr_stable", {tl_rd[i], tl_addr[i]}, {1'b1, 8'h01});
        check("wait_w_before_ack", tl_w[4], 8'h00);
        check("wait_w_after_ack", tl_w[5], 8'h55);
        check("wait_c6_quiet", tl_strb[5], 4'b0000);
        check("wait_c7_exec", tl_strb[6], 4'b1000);
        finish_phase("wait");

        // eight pushes: seven strobes then overflow fault
        for (int i = 0; i < 256; i++) rom_mem[i] = 8'h30;
        start_phase(8, 0);
        finish_phase("overflow");

        // pop from empty stack
        for (int i = 0; i < 256; i++) rom_mem[i] = 8'h20;
        start_phase(1, 0);
        finish_phase("underflow");

        // multibyte + push: exec, wb_hi, push on consecutive cycles
        clear_rom();
        rom_mem[0] = 8'h38; rom_mem[1] = 8'h00;
        start_phase(1, 0);
        capture(7);
        check("mb_exec", tl_strb[3], 4'b1000);
        check("mb_wb_hi", tl_strb[4], 4'b0100);
        check("mb_push", tl_strb[5], 4'b0010);
        check("mb_next_fetch", {tl_rd[6], tl_addr[6]}, {1'b1, 8'h02});
        finish_phase("mb_push");

        // halt requested during DECODE
        rom_mem[0] = 8'h10; rom_mem[1] = 8'h55; rom_mem[2] = 8'h10; rom_mem[3] = 8'h66;
        start_phase(2, 0);
        c = 0;
        while (state != 4'd3 && c < 100) begin @(negedge clk); c++; end
        check("halt_reach_decode", state, 4'd3);
        halt_req = 1'b1;
        c = 0;
        while (!halted && c < 100) begin @(negedge clk); c++; end
        check("halt_entered", halted, 1'b1);
        check("halt_pc_held", {rom.rom_rd, rom.rom_addr}, {1'b0, 8'h02});
        check("halt_first_done", 64'(exp_q.size()), 64'd3);
        repeat (4) @(negedge clk);
        check("halt_hold", {halted, state, rom.rom_addr, rom.rom_rd}, {1'b1, 4'd7, 8'h02, 1'b0});
        halt_req = 1'b0;
        finish_phase("halt_resume");

        // asynchronous reset in the middle of EXEC
        rom_mem[0] = 8'h10; rom_mem[1] = 8'h55;
        start_phase(1, 0);
        c = 0;
        while (!exec_en && c < 100) begin @(negedge clk); c++; end
        check("midexec_reached", exec_en, 1'b1);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("midexec_reset");
        start_phase(1, 0);
        finish_phase("after_reset");

        // randomized programs with random ROM latency
        for (int p = 0; p < 30; p++) begin
            for (int i = 0; i < 256; i++) begin
                rom_mem[i] = 8'($urandom);
                if ($urandom_range(0, 3) != 0) rom_mem[i][5] = 1'b0;
            end
            start_phase(int'($urandom_range(1, 16)), -1);
            finish_phase("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
